// File: rtl/pixelbuffer_ctrl_pkg.sv
// Shared types and constants for the pixel window buffer frame sequencer.
// The optional flush stage is selected by PIXBUF_CTRL_FLUSH_EN.
package pixelbuffer_ctrl_pkg;

    localparam int unsigned DEF_PIX_W  = 8;
    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DEPTH  = 8192;
    localparam int unsigned COORD_W    = 12;
    localparam int unsigned MIN_SIZE   = 3;
    localparam int unsigned RING_EXTRA = 3;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pixelbuffer_ctrl_cnt.sv
// 2-D raster counter: x runs 0..size_x-1, then wraps and steps y; last_c flags the final position.
module pixelbuffer_ctrl_cnt
    import pixelbuffer_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    input  coord_t size_x,
    input  coord_t size_y,
    output coord_t x,
    output coord_t y,
    output logic   last_c
);

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   x_wrap_c;
    logic   y_wrap_c;

    assign x_wrap_c = (x_q == size_x - coord_t'(1));
    assign y_wrap_c = (y_q == size_y - coord_t'(1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_wrap_c) begin
                x_d = '0;
                y_d = y_wrap_c ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign last_c = x_wrap_c && y_wrap_c;

endmodule

// File: rtl/pixelbuffer_ctrl.sv
// Frame sequencer feeding the 3x3 window buffer and its line RAM ring; flags valid window centres.
// Define PIXBUF_CTRL_FLUSH_EN to append size_x+1 zero pixels so every centre gets a window.
module pixelbuffer_ctrl
    import pixelbuffer_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       size_x,
    input  logic [11:0]       size_y,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PIX_W-1:0]  buf_pixel,
    output logic              buf_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic              win_valid,
    output logic [11:0]       win_x,
    output logic [11:0]       win_y,
    output logic              win_border,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    // One bit wider than the address so 2*size_x+3 and DEPTH never wrap.
    localparam int unsigned CMP_W = ADDR_W + 1;

    state_t             state_q, state_d;
    coord_t             sx_q, sx_d;
    coord_t             sy_q, sy_d;
    logic [PIX_W-1:0]   buf_pixel_q, buf_pixel_d;
    logic               buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [CMP_W-1:0]   n_q, n_d;
    logic               win_valid_q, win_valid_d;
    coord_t             win_x_q, win_x_d;
    coord_t             win_y_q, win_y_d;
    logic               win_border_q, win_border_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    coord_t             flush_cnt_q, flush_cnt_d;

    logic               hs_c, flush_beat_c, push_c, size_ok_c, in_last_c, win_last_c;
    logic [CMP_W-1:0]   ring_need_c, win_start_c;
    logic [ADDR_W-1:0]  ring_last_c;
    coord_t             in_x, in_y, wc_x, wc_y;
    logic               unused_c;

    assign in_ready     = (state_q == RUN);
    assign hs_c         = in_valid && in_ready;
    assign flush_beat_c = (state_q == FLUSH);
    assign push_c       = hs_c || flush_beat_c;

    assign ring_need_c = (CMP_W'(size_x) << 1) + CMP_W'(RING_EXTRA);
    assign size_ok_c   = (CMP_W'(size_x) >= CMP_W'(MIN_SIZE))
                      && (CMP_W'(size_y) >= CMP_W'(MIN_SIZE))
                      && (ring_need_c <= CMP_W'(DEPTH));
    assign ring_last_c = ADDR_W'((CMP_W'(sx_q) << 1) + CMP_W'(2));
    assign win_start_c = CMP_W'(sx_q) + CMP_W'(2);

    // Input raster position: detects the last accepted pixel.
    pixelbuffer_ctrl_cnt u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == IDLE),
        .en     (hs_c),
        .size_x (sx_q),
        .size_y (sy_q),
        .x      (in_x),
        .y      (in_y),
        .last_c (in_last_c)
    );

    // Window centre position: always points at the next centre to be issued.
    pixelbuffer_ctrl_cnt u_win_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == IDLE),
        .en     (win_valid_d),
        .size_x (sx_q),
        .size_y (sy_q),
        .x      (wc_x),
        .y      (wc_y),
        .last_c (win_last_c)
    );

    assign unused_c = ^{in_x, in_y, win_last_c};

    always_comb begin
        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        buf_pixel_d  = buf_pixel_q;
        buf_valid_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        n_d          = n_q;
        win_valid_d  = 1'b0;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_border_d = win_border_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        flush_cnt_d  = flush_cnt_q;

        if (push_c) begin
            buf_valid_d = 1'b1;
            buf_pixel_d = hs_c ? in_pixel : '0;
            if (n_q < win_start_c) begin
                n_d = n_q + CMP_W'(1);
            end
        end

        if (buf_valid_q) begin
            ram_addr_d  = (ram_addr_q == ring_last_c) ? '0 : ram_addr_q + ADDR_W'(1);
            win_valid_d = (n_q >= win_start_c);
        end

        if (win_valid_d) begin
            win_x_d      = wc_x;
            win_y_d      = wc_y;
            win_border_d = (wc_x == '0) || (wc_x == sx_q - coord_t'(1))
                        || (wc_y == '0) || (wc_y == sy_q - coord_t'(1));
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_ok_c) begin
                        sx_d        = size_x;
                        sy_d        = size_y;
                        n_d         = '0;
                        ram_addr_d  = '0;
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (hs_c && in_last_c) begin
`ifdef PIXBUF_CTRL_FLUSH_EN
                    state_d = FLUSH;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef PIXBUF_CTRL_FLUSH_EN
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + coord_t'(1);
                if (flush_cnt_q == sx_q) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                // Leave only once the last window flag has been presented.
                if (!buf_valid_q && !win_valid_q) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            buf_pixel_q  <= '0;
            buf_valid_q  <= 1'b0;
            ram_addr_q   <= '0;
            n_q          <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_border_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            buf_pixel_q  <= buf_pixel_d;
            buf_valid_q  <= buf_valid_d;
            ram_addr_q   <= ram_addr_d;
            n_q          <= n_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_border_q <= win_border_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign buf_pixel  = buf_pixel_q;
    assign buf_valid  = buf_valid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_ren    = buf_valid_q;
    assign ram_wen    = buf_valid_q;
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign win_border = win_border_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pixelbuffer_ctrl.sv
// Directed bench for pixelbuffer_ctrl: frames, size rejection, ring addressing, gaps and mid-frame reset.
module tb_pixelbuffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] size_x, size_y;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  buf_pixel;
    logic        buf_valid;
    logic [12:0] ram_addr;
    logic        ram_ren, ram_wen;
    logic        win_valid;
    logic [11:0] win_x, win_y;
    logic        win_border;
    logic        busy, frame_done, err;

    always #5 clk = ~clk;

    pixelbuffer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .size_x     (size_x),
        .size_y     (size_y),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .buf_pixel  (buf_pixel),
        .buf_valid  (buf_valid),
        .ram_addr   (ram_addr),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .win_border (win_border),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] win_log[$];
    int          pix_log[$];
    int          addr_log[$];
    int          fd_cnt, err_cnt, viol_cnt;
    logic        prev_bv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Passive log of DUT activity, sampled on the falling edge.
    always @(negedge clk) begin
        if (win_valid) begin
            win_log.push_back({win_x, win_y, win_border});
            if (!prev_bv) viol_cnt++;
        end
        if (buf_valid) begin
            pix_log.push_back(int'(buf_pixel));
            addr_log.push_back(int'(ram_addr));
        end
        if (ram_ren !== buf_valid || ram_wen !== buf_valid) viol_cnt++;
        if (frame_done) fd_cnt++;
        if (err) err_cnt++;
        prev_bv = buf_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        win_log.delete();
        pix_log.delete();
        addr_log.delete();
        fd_cnt   = 0;
        err_cnt  = 0;
        viol_cnt = 0;
    endtask

    task automatic do_start(input int sx, input int sy);
        size_x = 12'(sx);
        size_y = 12'(sy);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic feed(input int total, input bit gaps);
        int acc   = 0;
        int guard = 0;
        bit hs;
        while (acc < total && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_pixel = 8'(acc + 1);
            hs = in_valid && in_ready;
            step();
            if (hs) acc++;
            guard++;
        end
        in_valid = 1'b0;
        check("feed_accepted", 32'(acc), 32'(total));
    endtask

    task automatic wait_done();
        int guard = 0;
        while (fd_cnt == 0 && guard < 200) begin
            step();
            guard++;
        end
        check("frame_done_seen", 32'(fd_cnt), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
    endtask

    task automatic check_windows(input int sx, input int sy, input int exp_n);
        int lim;
        check("win_count", 32'(win_log.size()), 32'(exp_n));
        lim = (win_log.size() < exp_n) ? win_log.size() : exp_n;
        for (int i = 0; i < lim; i++) begin
            int x, y;
            logic b;
            x = i % sx;
            y = i / sx;
            b = (x == 0) || (x == sx - 1) || (y == 0) || (y == sy - 1);
            check($sformatf("win_xyb[%0d]", i), 32'(win_log[i]), 32'({12'(x), 12'(y), b}));
        end
    endtask

    initial begin
        int exp_pix;
        rst = 1'b0; start = 1'b0; size_x = '0; size_y = '0;
        in_pixel = '0; in_valid = 1'b0;
        clear_logs();

        // Reset state
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_buf_valid", 32'(buf_valid), 32'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_flags", 32'({frame_done, err, win_border}), 32'd0);
        rst = 1'b1;
        step();

        // 4x3 frame, continuous input
        clear_logs();
        do_start(4, 3);
        check("run_busy", 32'(busy), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd1);
        feed(12, 1'b0);
        wait_done();
`ifdef PIXBUF_CTRL_FLUSH_EN
        check_windows(4, 3, 12);
        exp_pix = 17;
`else
        check_windows(4, 3, 7);
        exp_pix = 12;
`endif
        check("f43_pix_count", 32'(pix_log.size()), 32'(exp_pix));
        for (int i = 0; i < pix_log.size() && i < exp_pix; i++)
            check($sformatf("f43_pix[%0d]", i), 32'(pix_log[i]), (i < 12) ? 32'(i + 1) : 32'd0);
        check("f43_viol", 32'(viol_cnt), 32'd0);
        check("f43_no_err", 32'(err_cnt), 32'd0);

        // Rejected sizes
        clear_logs();
        do_start(2, 3);
        check("err_sx2", 32'(err), 32'd1);
        check("err_sx2_busy", 32'(busy), 32'd0);
        step();
        check("err_sx2_pulse", 32'(err), 32'd0);
        do_start(4095, 3);
        check("err_sx4095", 32'(err), 32'd1);
        check("err_sx4095_busy", 32'(busy), 32'd0);
        do_start(5, 2);
        check("err_sy2", 32'(err), 32'd1);
        step();
        check("err_idle_ready", 32'(in_ready), 32'd0);
        check("err_total", 32'(err_cnt), 32'd3);

        // Ring addressing, size_x=3
        clear_logs();
        do_start(3, 7);
        feed(21, 1'b0);
        wait_done();
        check("ring_len", 32'(addr_log.size() >= 20), 32'd1);
        for (int i = 0; i < 20 && i < addr_log.size(); i++)
            check($sformatf("ring_addr[%0d]", i), 32'(addr_log[i]), 32'(i % 9));
        check("ring_viol", 32'(viol_cnt), 32'd0);

        // 5x5 frame with random input gaps
        clear_logs();
        do_start(5, 5);
        feed(25, 1'b1);
        wait_done();
`ifdef PIXBUF_CTRL_FLUSH_EN
        check_windows(5, 5, 25);
`else
        check_windows(5, 5, 19);
`endif
        check("gap_viol", 32'(viol_cnt), 32'd0);

        // Start ignored mid-run, then reset aborts the frame
        clear_logs();
        do_start(5, 5);
        feed(4, 1'b0);
        size_x = 12'd3; size_y = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid_start_busy", 32'(busy), 32'd1);
        check("mid_start_err", 32'(err), 32'd0);
        feed(5, 1'b0);
        step(); step();
        check("mid_win_count", 32'(win_log.size()), 32'd3);
        check("mid_win_x", 32'(win_x), 32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_win", 32'({win_valid, win_x, win_y, win_border}), 32'd0);
        check("abort_buf", 32'({buf_valid, ram_addr}), 32'd0);
        repeat (30) step();
        check("abort_no_done", 32'(fd_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
